// File: rtl/store_commit_unit_if.sv
// -----------------------------------------------------------------------------
// store_commit_unit_if
//
// Purpose:
//    Data-cache write port used by the store commit unit. The commit unit is
//    the master: it raises a write request and holds it until the cache
//    acknowledges. The cache is the slave: it acknowledges, reports hit or
//    miss, and later pulses a refill-done strobe for an outstanding miss.
//
// Signals:
//    dcWriteReq     master -> slave   write request valid
//    dcWriteAddr    master -> slave   block address   (BLOCK_ADDR_W)
//    dcWriteData    master -> slave   block data      (BLOCK_DATA_W)
//    dcWriteWordWE  master -> slave   word enables    (WORD_NUM)
//    dcWriteByteWE  master -> slave   byte enables    (WORD_BYTE)
//    dcWriteAck     slave  -> master  request accepted this cycle
//    dcWriteHit     slave  -> master  qualifies dcWriteAck: 1 written, 0 miss
//    dcRefillDone   slave  -> master  one-cycle pulse, outstanding miss refilled
// -----------------------------------------------------------------------------
interface store_commit_unit_if #(
   parameter int BLOCK_ADDR_W = 28,
   parameter int BLOCK_DATA_W = 128,
   parameter int WORD_NUM     = 4,
   parameter int WORD_BYTE    = 4
);
   logic                    dcWriteReq;
   logic [BLOCK_ADDR_W-1:0] dcWriteAddr;
   logic [BLOCK_DATA_W-1:0] dcWriteData;
   logic [WORD_NUM-1:0]     dcWriteWordWE;
   logic [WORD_BYTE-1:0]    dcWriteByteWE;
   logic                    dcWriteAck;
   logic                    dcWriteHit;
   logic                    dcRefillDone;

   modport master (
      output dcWriteReq,
      output dcWriteAddr,
      output dcWriteData,
      output dcWriteWordWE,
      output dcWriteByteWE,
      input  dcWriteAck,
      input  dcWriteHit,
      input  dcRefillDone
   );

   modport slave (
      input  dcWriteReq,
      input  dcWriteAddr,
      input  dcWriteData,
      input  dcWriteWordWE,
      input  dcWriteByteWE,
      output dcWriteAck,
      output dcWriteHit,
      output dcRefillDone
   );
endinterface

// File: rtl/store_commit_unit.sv
// -----------------------------------------------------------------------------
// store_commit_unit
//
// Purpose:
//    Drains committed stores from the store-queue head to the data cache, one
//    store at a time and in program order. A store that misses in the cache is
//    reissued unchanged after the refill completes. Stores whose condition is
//    disabled retire without touching the cache. The SQ head is popped once
//    the store at the head has completed.
//
// Ports:
//    clk                            clock
//    rst                            asynchronous reset, active low
//    commitStoreNum                 stores committed this cycle (0..COMMIT_WIDTH)
//    retiredStoreQueuePtr           SQ head index; SQ answers combinationally
//    retiredStoreLSQ_BlockAddr      head store block address
//    retiredStoreData               head store data, already lane-aligned
//    retiredStoreCondEnabled        head store actually writes memory
//    retiredStoreWordWE             head store word enables
//    retiredStoreByteWE             head store byte enables
//    releaseStoreQueueHead          pop the SQ head this cycle
//    releaseStoreQueueHeadEntryNum  number of entries popped (0 or 1)
//    dc                             data-cache write port (master side)
//    storeCommitBusy                stores still outstanding or one in flight
//
// Optional feature (macro STORE_COMMIT_PERF_COUNTER_EN):
//    When defined, adds free-running, wrapping 32-bit counters
//    perfStoreWriteCount (acks with hit) and perfStoreMissCount (acks with
//    miss). When undefined, neither the ports nor the counters exist.
// -----------------------------------------------------------------------------
module store_commit_unit #(
   parameter  int SQ_ENTRY_NUM = 16,
   parameter  int COMMIT_WIDTH = 2,
   parameter  int BLOCK_ADDR_W = 28,
   parameter  int BLOCK_DATA_W = 128,
   parameter  int WORD_NUM     = 4,
   parameter  int WORD_BYTE    = 4,
   localparam int PTR_W        = $clog2(SQ_ENTRY_NUM),
   localparam int CNT_W        = $clog2(SQ_ENTRY_NUM + 1),
   localparam int CS_W         = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [CS_W-1:0]         commitStoreNum,

   output logic [PTR_W-1:0]        retiredStoreQueuePtr,
   input  logic [BLOCK_ADDR_W-1:0] retiredStoreLSQ_BlockAddr,
   input  logic [BLOCK_DATA_W-1:0] retiredStoreData,
   input  logic                    retiredStoreCondEnabled,
   input  logic [WORD_NUM-1:0]     retiredStoreWordWE,
   input  logic [WORD_BYTE-1:0]    retiredStoreByteWE,

   output logic                    releaseStoreQueueHead,
   output logic [CS_W-1:0]         releaseStoreQueueHeadEntryNum,

   store_commit_unit_if.master     dc,

   output logic                    storeCommitBusy
`ifdef STORE_COMMIT_PERF_COUNTER_EN
   ,
   output logic [31:0]             perfStoreWriteCount,
   output logic [31:0]             perfStoreMissCount
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQ       = 2'd1,
      S_MISS_WAIT = 2'd2
   } state_t;

   // Depth expressed in the widened pending arithmetic width, so the bound
   // check compares like-for-like.
   localparam logic [CNT_W:0] SQ_DEPTH_L = (CNT_W + 1)'(SQ_ENTRY_NUM);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNT_W-1:0]        r_pending;
   logic [PTR_W-1:0]        r_head_ptr;

   // Captured copy of the head store. Held untouched across REQ and
   // MISS_WAIT so a reissue after refill is bit-identical to the first try.
   logic [BLOCK_ADDR_W-1:0] r_req_addr;
   logic [BLOCK_DATA_W-1:0] r_req_data;
   logic [WORD_NUM-1:0]     r_req_word_we;
   logic [WORD_BYTE-1:0]    r_req_byte_we;

   logic                    w_capture;
   logic                    w_release;
   logic                    w_ack_hit;
   logic                    w_ack_miss;
   logic [CNT_W:0]          w_pending_sum;

   // Ack/hit only mean something while a request is actually on the bus.
   assign w_ack_hit  = (r_state == S_REQ) &&  dc.dcWriteAck &&  dc.dcWriteHit;
   assign w_ack_miss = (r_state == S_REQ) &&  dc.dcWriteAck && !dc.dcWriteHit;

   // ------------------------------------------------------------------------
   // Next-state and per-cycle control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_release    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (r_pending != '0) begin
               if (retiredStoreCondEnabled) begin
                  // Writing store: latch it and go ask the cache. The pop
                  // waits until the cache confirms the write.
                  w_capture    = 1'b1;
                  w_state_next = S_REQ;
               end else begin
                  // Non-writing store: nothing to send, just retire it.
                  w_release    = 1'b1;
               end
            end
         end

         S_REQ: begin
            if (w_ack_hit) begin
               w_release    = 1'b1;
               w_state_next = S_IDLE;
            end else if (w_ack_miss) begin
               w_state_next = S_MISS_WAIT;
            end
         end

         S_MISS_WAIT: begin
            // Refill strobes outside this state carry no meaning here.
            if (dc.dcRefillDone) begin
               w_state_next = S_REQ;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Commit and release can land in the same cycle; one extra bit keeps an
   // out-of-range result visible to the bound check instead of wrapping.
   assign w_pending_sum = {1'b0, r_pending}
                        + (CNT_W + 1)'(commitStoreNum)
                        - (CNT_W + 1)'(w_release);

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pending  <= '0;
         r_head_ptr <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pending  <= w_pending_sum[CNT_W-1:0];
         if (w_release) begin
            // Power-of-two depth: natural wrap of PTR_W bits.
            r_head_ptr <= r_head_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req_addr    <= '0;
         r_req_data    <= '0;
         r_req_word_we <= '0;
         r_req_byte_we <= '0;
      end else if (w_capture) begin
         r_req_addr    <= retiredStoreLSQ_BlockAddr;
         r_req_data    <= retiredStoreData;
         r_req_word_we <= retiredStoreWordWE;
         r_req_byte_we <= retiredStoreByteWE;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign retiredStoreQueuePtr          = r_head_ptr;
   assign releaseStoreQueueHead         = w_release;
   assign releaseStoreQueueHeadEntryNum = CS_W'(w_release);

   assign dc.dcWriteReq    = (r_state == S_REQ);
   assign dc.dcWriteAddr   = r_req_addr;
   assign dc.dcWriteData   = r_req_data;
   assign dc.dcWriteWordWE = r_req_word_we;
   assign dc.dcWriteByteWE = r_req_byte_we;

   // Fence/flush logic must wait while anything is queued or in flight.
   assign storeCommitBusy = (r_pending != '0) || (r_state != S_IDLE);

`ifdef STORE_COMMIT_PERF_COUNTER_EN
   // ------------------------------------------------------------------------
   // Performance counters (wrap on overflow)
   // ------------------------------------------------------------------------
   logic [31:0] r_perf_write_cnt;
   logic [31:0] r_perf_miss_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_write_cnt <= '0;
         r_perf_miss_cnt  <= '0;
      end else begin
         if (w_ack_hit) begin
            r_perf_write_cnt <= r_perf_write_cnt + 32'd1;
         end
         if (w_ack_miss) begin
            r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
         end
      end
   end

   assign perfStoreWriteCount = r_perf_write_cnt;
   assign perfStoreMissCount  = r_perf_miss_cnt;
`endif

   // ------------------------------------------------------------------------
   // Occupancy sanity: the SQ can never hold more than its depth, and a
   // release is only legal when something is outstanding.
   // ------------------------------------------------------------------------
   a_pending_bound : assert property (
      @(posedge clk) disable iff (!rst) (w_pending_sum <= SQ_DEPTH_L)
   );

   a_no_underflow : assert property (
      @(posedge clk) disable iff (!rst) !(w_release && (r_pending == '0))
   );

endmodule

// File: tb/tb_store_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_store_commit_unit
//
// Bench for store_commit_unit. The SQ is a small array indexed by the DUT's
// head pointer; the cache is a responder with tunable ack/hit/refill
// behaviour. A reference model keeps the outstanding stores as a queue in
// program order and derives, every cycle, what the request, release, pointer
// and busy outputs must be. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_store_commit_unit;

   localparam int SQN = 16;
   localparam int AW  = 28;
   localparam int DW  = 128;
   localparam int WN  = 4;
   localparam int WB  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]    commitStoreNum = 2'd0;
   logic [3:0]    retiredStoreQueuePtr;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          head_cond;
   logic [WN-1:0] head_wwe;
   logic [WB-1:0] head_bwe;
   logic          releaseStoreQueueHead;
   logic [1:0]    releaseStoreQueueHeadEntryNum;
   logic          storeCommitBusy;
`ifdef STORE_COMMIT_PERF_COUNTER_EN
   logic [31:0]   perf_w;
   logic [31:0]   perf_m;
`endif

   // Store-queue storage, read combinationally at the DUT's head pointer.
   logic [AW-1:0] sq_addr [SQN];
   logic [DW-1:0] sq_data [SQN];
   logic          sq_cond [SQN];
   logic [WN-1:0] sq_wwe  [SQN];
   logic [WB-1:0] sq_bwe  [SQN];

   assign head_addr = sq_addr[retiredStoreQueuePtr];
   assign head_data = sq_data[retiredStoreQueuePtr];
   assign head_cond = sq_cond[retiredStoreQueuePtr];
   assign head_wwe  = sq_wwe[retiredStoreQueuePtr];
   assign head_bwe  = sq_bwe[retiredStoreQueuePtr];

   store_commit_unit_if #(.BLOCK_ADDR_W(AW), .BLOCK_DATA_W(DW),
                          .WORD_NUM(WN), .WORD_BYTE(WB)) dc ();

   store_commit_unit #(
      .SQ_ENTRY_NUM(SQN), .COMMIT_WIDTH(2), .BLOCK_ADDR_W(AW),
      .BLOCK_DATA_W(DW), .WORD_NUM(WN), .WORD_BYTE(WB)
   ) dut (
      .clk                           (clk),
      .rst                           (rst),
      .commitStoreNum                (commitStoreNum),
      .retiredStoreQueuePtr          (retiredStoreQueuePtr),
      .retiredStoreLSQ_BlockAddr     (head_addr),
      .retiredStoreData              (head_data),
      .retiredStoreCondEnabled       (head_cond),
      .retiredStoreWordWE            (head_wwe),
      .retiredStoreByteWE            (head_bwe),
      .releaseStoreQueueHead         (releaseStoreQueueHead),
      .releaseStoreQueueHeadEntryNum (releaseStoreQueueHeadEntryNum),
      .dc                            (dc),
      .storeCommitBusy               (storeCommitBusy)
`ifdef STORE_COMMIT_PERF_COUNTER_EN
      ,
      .perfStoreWriteCount           (perf_w),
      .perfStoreMissCount            (perf_m)
`endif
   );

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: outstanding stores in program order
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic          cond;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [WN-1:0] wwe;
      logic [WB-1:0] bwe;
   } st_t;

   st_t mq[$];
   int  head_cnt  = 0;   // stores released since reset
   int  tail_cnt  = 0;   // stores committed since reset
   int  head_age  = 0;   // cycles the current head has been at the head
   bit  miss_wait = 0;   // current head is waiting for a refill
   int  exp_writes = 0;
   int  exp_misses = 0;
   bit  chk_en = 0;

   task automatic model_clear();
      mq.delete();
      head_cnt = 0; tail_cnt = 0; head_age = 0; miss_wait = 0;
      exp_writes = 0; exp_misses = 0;
   endtask

   // Rules: a non-writing head retires in its first cycle at the head; a
   // writing head is requested from its second cycle onward unless a miss
   // is outstanding; a hit ack retires it in the same cycle.
   task automatic model_step();
      bit  has_head;
      bit  exp_req;
      bit  exp_rel;
      st_t h;
      has_head = (mq.size() != 0);
      h = has_head ? mq[0] : '0;
      exp_req = has_head && h.cond && (head_age > 0) && !miss_wait;
      exp_rel = has_head && (!h.cond || (exp_req && dc.dcWriteAck && dc.dcWriteHit));

      chk("ptr", 128'(retiredStoreQueuePtr), 128'(head_cnt % SQN));
      chk("busy", 128'(storeCommitBusy), 128'(has_head));
      chk("dcWriteReq", 128'(dc.dcWriteReq), 128'(exp_req));
      chk("release", 128'(releaseStoreQueueHead), 128'(exp_rel));
      chk("releaseEntryNum", 128'(releaseStoreQueueHeadEntryNum), 128'(exp_rel));
      if (exp_req) begin
         chk("req_addr", 128'(dc.dcWriteAddr), 128'(h.addr));
         chk("req_data", dc.dcWriteData, h.data);
         chk("req_wordwe", 128'(dc.dcWriteWordWE), 128'(h.wwe));
         chk("req_bytewe", 128'(dc.dcWriteByteWE), 128'(h.bwe));
      end
`ifdef STORE_COMMIT_PERF_COUNTER_EN
      chk("perf_write", 128'(perf_w), 128'(32'(exp_writes)));
      chk("perf_miss", 128'(perf_m), 128'(32'(exp_misses)));
`endif

      if (exp_req && dc.dcWriteAck) begin
         if (dc.dcWriteHit) exp_writes++;
         else begin exp_misses++; miss_wait = 1; end
      end else if (miss_wait && dc.dcRefillDone) begin
         miss_wait = 0;
      end

      if (exp_rel) begin
         $display("retire n=%0d ptr=%0d cond=%0b addr=%h", head_cnt, head_cnt % SQN, h.cond, h.addr);
         void'(mq.pop_front());
         head_cnt++;
         head_age = 0;
      end else if (has_head) begin
         head_age++;
      end

      for (int k = 0; k < int'(commitStoreNum); k++) begin
         int idx;
         idx = (tail_cnt + k) % SQN;
         mq.push_back({sq_cond[idx], sq_addr[idx], sq_data[idx], sq_wwe[idx], sq_bwe[idx]});
      end
      tail_cnt += int'(commitStoreNum);
   endtask

   always begin
      @(negedge clk);
      #2;
      if (chk_en && rst) model_step();
   end

   // ------------------------------------------------------------------------
   // Stimulus: SQ writer and cache responder
   // ------------------------------------------------------------------------
   int staged = 0;
   int ack_pct = 100, hit_pct = 100, spur_pct = 0;
   int force_miss = 0, refill_delay = 5, refill_cnt = -1;
   bit hold_ack = 0, rand_refill = 0;

   task automatic stage(input logic cond, input logic [AW-1:0] a);
      int idx;
      idx = (tail_cnt + staged) % SQN;
      sq_cond[idx] = cond;
      sq_addr[idx] = a;
      sq_data[idx] = {$urandom, $urandom, $urandom, $urandom};
      sq_wwe[idx]  = WN'($urandom);
      sq_bwe[idx]  = WB'($urandom);
      staged++;
   endtask

   task automatic drive_cache();
      dc.dcWriteAck   = 1'b0;
      dc.dcWriteHit   = 1'($urandom);   // meaningless without ack
      dc.dcRefillDone = 1'b0;
      if (refill_cnt > 0) begin
         refill_cnt--;
         if (refill_cnt == 0) dc.dcRefillDone = 1'b1;
      end
      if (spur_pct > 0 && $urandom_range(99) < 32'(spur_pct)) dc.dcRefillDone = 1'b1;
      if (dc.dcWriteReq === 1'b1 && !hold_ack && $urandom_range(99) < 32'(ack_pct)) begin
         dc.dcWriteAck = 1'b1;
         if (force_miss > 0) begin
            dc.dcWriteHit = 1'b0;
            force_miss--;
         end else begin
            dc.dcWriteHit = ($urandom_range(99) < 32'(hit_pct));
         end
         if (!dc.dcWriteHit) refill_cnt = rand_refill ? int'($urandom_range(8, 1)) : refill_delay;
      end
   endtask

   // Called right after a falling edge: apply this cycle's inputs, then wait
   // past the model check so literal checks see settled outputs.
   task automatic cyc();
      commitStoreNum = 2'(staged);
      staged = 0;
      drive_cache();
      #4;
   endtask

   task automatic apply_reset();
      chk_en = 0;
      rst = 1'b0;
      commitStoreNum = 2'd0;
      dc.dcWriteAck = 1'b0; dc.dcWriteHit = 1'b0; dc.dcRefillDone = 1'b0;
      staged = 0; refill_cnt = -1; force_miss = 0; hold_ack = 0;
      ack_pct = 100; hit_pct = 100; spur_pct = 0; rand_refill = 0; refill_delay = 5;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ptr", 128'(retiredStoreQueuePtr), 128'(0));
      chk("rst_busy", 128'(storeCommitBusy), 128'(0));
      chk("rst_req", 128'(dc.dcWriteReq), 128'(0));
      chk("rst_release", 128'(releaseStoreQueueHead), 128'(0));
      chk("rst_entrynum", 128'(releaseStoreQueueHeadEntryNum), 128'(0));
      chk("rst_addr", 128'(dc.dcWriteAddr), 128'(0));
      chk("rst_data", dc.dcWriteData, 128'(0));
      chk("rst_wwe", 128'(dc.dcWriteWordWE), 128'(0));
      chk("rst_bwe", 128'(dc.dcWriteByteWE), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1;
      cyc();
   endtask

   task automatic drain(input string nm, output int nrel);
      int k;
      nrel = 0;
      k = 0;
      while ((mq.size() != 0 || storeCommitBusy === 1'b1) && k < 400) begin
         @(negedge clk);
         cyc();
         if (releaseStoreQueueHead === 1'b1) nrel++;
         k++;
      end
      chk(nm, 128'(mq.size() != 0 || storeCommitBusy !== 1'b0), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Sequences
   // ------------------------------------------------------------------------
   initial begin
      int nrel, nreq, issued, n, room;
      for (int i = 0; i < SQN; i++) begin
         sq_addr[i] = '0; sq_data[i] = '0; sq_cond[i] = 1'b0; sq_wwe[i] = '0; sq_bwe[i] = '0;
      end
      dc.dcWriteAck = 1'b0; dc.dcWriteHit = 1'b0; dc.dcRefillDone = 1'b0;

      // 1) single hitting store: request one cycle after capture, release on ack
      apply_reset();
      @(negedge clk); stage(1'b1, 28'h10); cyc();
      chk("t1_busy_commit", 128'(storeCommitBusy), 128'(0));
      @(negedge clk); cyc();
      chk("t1_req_capture", 128'(dc.dcWriteReq), 128'(0));
      chk("t1_busy_capture", 128'(storeCommitBusy), 128'(1));
      @(negedge clk); cyc();
      chk("t1_req", 128'(dc.dcWriteReq), 128'(1));
      chk("t1_addr", 128'(dc.dcWriteAddr), 128'(28'h10));
      chk("t1_release", 128'(releaseStoreQueueHead), 128'(1));
      chk("t1_ptr_before", 128'(retiredStoreQueuePtr), 128'(0));
      @(negedge clk); cyc();
      chk("t1_ptr_after", 128'(retiredStoreQueuePtr), 128'(1));
      chk("t1_busy_after", 128'(storeCommitBusy), 128'(0));
      chk("t1_release_after", 128'(releaseStoreQueueHead), 128'(0));

      // 2) two stores in one cycle, second non-writing
      apply_reset();
      @(negedge clk); stage(1'b1, 28'h20); stage(1'b0, 28'h24); cyc();
      @(negedge clk); cyc();
      @(negedge clk); cyc();
      chk("t2_first_release", 128'(releaseStoreQueueHead), 128'(1));
      @(negedge clk); cyc();
      chk("t2_second_release", 128'(releaseStoreQueueHead), 128'(1));
      chk("t2_second_noreq", 128'(dc.dcWriteReq), 128'(0));
      chk("t2_ptr_mid", 128'(retiredStoreQueuePtr), 128'(1));
      @(negedge clk); cyc();
      chk("t2_ptr_end", 128'(retiredStoreQueuePtr), 128'(2));
      chk("t2_busy_end", 128'(storeCommitBusy), 128'(0));

      // 3) miss, refill 5 cycles later, identical reissue, one release
      apply_reset();
      force_miss = 1; refill_delay = 5;
      @(negedge clk); stage(1'b1, 28'h30); cyc();
      nreq = 0; nrel = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); cyc();
         if (dc.dcWriteReq === 1'b1) nreq++;
         if (releaseStoreQueueHead === 1'b1) nrel++;
      end
      chk("t3_req_cycles", 128'(nreq), 128'(2));
      chk("t3_releases", 128'(nrel), 128'(1));
      chk("t3_ptr", 128'(retiredStoreQueuePtr), 128'(1));

      // 4) request held 10 cycles while 3 more stores commit
      apply_reset();
      hold_ack = 1;
      @(negedge clk); stage(1'b1, 28'h50); cyc();
      @(negedge clk); cyc();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) begin stage(1'b1, 28'h54); stage(1'b0, 28'h58); end
         if (i == 5) stage(1'b1, 28'h5c);
         cyc();
         chk("t4_hold_req", 128'(dc.dcWriteReq), 128'(1));
         chk("t4_hold_addr", 128'(dc.dcWriteAddr), 128'(28'h50));
      end
      chk("t4_ptr_held", 128'(retiredStoreQueuePtr), 128'(0));
      hold_ack = 0;
      drain("t4_drain", nrel);
      chk("t4_releases", 128'(nrel), 128'(4));
      chk("t4_ptr_end", 128'(retiredStoreQueuePtr), 128'(4));

      // 5) pointer wrap: 17 stores
      apply_reset();
      issued = 0;
      while (issued < 17) begin
         @(negedge clk);
         if (mq.size() < SQN) begin
            stage(1'($urandom), 28'($urandom));
            issued++;
         end
         cyc();
      end
      drain("t5_drain", nrel);
      chk("t5_ptr_wrap", 128'(retiredStoreQueuePtr), 128'(1));

      // 6) asynchronous reset while waiting for a refill
      apply_reset();
      force_miss = 1; refill_delay = 1000;
      @(negedge clk); stage(1'b0, 28'h40); stage(1'b1, 28'h44); cyc();
      repeat (5) begin @(negedge clk); cyc(); end
      chk("t6_wait_req", 128'(dc.dcWriteReq), 128'(0));
      chk("t6_wait_busy", 128'(storeCommitBusy), 128'(1));
      chk("t6_wait_ptr", 128'(retiredStoreQueuePtr), 128'(1));
      @(posedge clk); #3;
      chk_en = 0;
      rst = 1'b0;
      #1;
      chk("t6_async_ptr", 128'(retiredStoreQueuePtr), 128'(0));
      chk("t6_async_busy", 128'(storeCommitBusy), 128'(0));
      chk("t6_async_req", 128'(dc.dcWriteReq), 128'(0));
      chk("t6_async_addr", 128'(dc.dcWriteAddr), 128'(0));

      // 7) randomized traffic against the model
      apply_reset();
      ack_pct = 60; hit_pct = 70; spur_pct = 5; rand_refill = 1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         room = SQN - mq.size();
         n = ($urandom_range(99) < 30) ? int'($urandom_range(2, 1)) : 0;
         if (n > room) n = room;
         for (int k = 0; k < n; k++) stage($urandom_range(99) < 75, 28'($urandom));
         cyc();
      end
      ack_pct = 100; hit_pct = 100; spur_pct = 0;
      drain("t7_drain", nrel);
      chk("t7_ptr_end", 128'(retiredStoreQueuePtr), 128'(head_cnt % SQN));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
